// File: rtl/fetch_responder_pkg.sv
// Shared types and default sizing for the instruction fetch responder.
// The fault field of the FIFO entry exists only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 64;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
`ifdef FETCH_ALIGN_CHECK_EN
        logic                   fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_responder_if.sv
// PC, memory and decode-side signals of the fetch responder.
// instr_fault is present only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_responder_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               pc_valid;
    logic [ADDR_W-1:0]  pc;
    logic               pc_ready;
    logic               flush;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic               instr_fault;
`endif

    modport slave (
        input  pc_valid, pc, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
`ifdef FETCH_ALIGN_CHECK_EN
        output instr_fault,
`endif
        output pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport master (
        output pc_valid, pc, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
`ifdef FETCH_ALIGN_CHECK_EN
        input  instr_fault,
`endif
        input  pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/fetch_responder_fifo.sv
// First-word-fall-through FIFO holding fetched entries; clear beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !clear;
    assign w_pop  = pop && (r_count != '0) && !clear;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/fetch_responder.sv
// Fetch responder: accepts PCs, issues one outstanding memory read, buffers results for decode.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned PCs into faulting entries without a memory read.
module fetch_responder
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic            clock,
    input  logic            reset,
    fetch_responder_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
`ifdef FETCH_ALIGN_CHECK_EN
        logic               fault;
`endif
    } entry_t;

    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic              w_pc_ready;
    logic              w_push;
    logic              w_misaligned;
    logic              w_accept;
    entry_t            w_wdata;
    entry_t            w_head;
    logic [CW-1:0]     w_count;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (bus.pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Next-state, acceptance and FIFO push decode.
    always_comb begin
        w_next      = r_state;
        w_pc_ready  = 1'b0;
        w_push      = 1'b0;
        w_wdata     = '0;
        w_wdata.pc  = r_mem_addr;
        w_wdata.instr = bus.mem_rdata;
        case (r_state)
            S_IDLE: begin
                w_pc_ready = reset && (w_count < FULL) && !bus.flush;
                if (bus.pc_valid && w_pc_ready) begin
                    if (w_misaligned) begin
                        w_push        = 1'b1;
                        w_wdata.pc    = bus.pc;
                        w_wdata.instr = '0;
`ifdef FETCH_ALIGN_CHECK_EN
                        w_wdata.fault = 1'b1;
`endif
                        w_next        = S_IDLE;
                    end else begin
                        w_next = S_REQ;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.flush) begin
                    w_next = S_IDLE;
                end else if (bus.mem_gnt) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_push = !bus.flush;
                    w_next = S_IDLE;
                end else if (bus.flush) begin
                    w_next = S_DISCARD;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (bus.mem_rvalid) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DISCARD;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = bus.pc_valid && w_pc_ready && !w_misaligned;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request address and registered request strobe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_addr <= bus.pc;
            end
            r_mem_req <= (w_next == S_REQ);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (bus.instr_ready),
        .clear (bus.flush),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count)
    );

    assign bus.pc_ready    = w_pc_ready;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr_valid = (w_count != '0);
    assign bus.instr       = w_head.instr;
    assign bus.instr_pc    = w_head.pc;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.instr_fault = w_head.fault;
`endif

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: vector table, directed corner sequences and a randomized run
// checked against a transaction-level model (queue of expected decode entries).
module tb_fetch_responder;
    import fetch_pkg::*;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int D  = 4;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    fetch_responder_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    fetch_responder #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
        logic          flt;
    } ent_t;

    ent_t          q[$];
    bit            m_wait_gnt = 1'b0;
    bit            m_wait_data = 1'b0;
    bit            m_drop = 1'b0;
    logic [AW-1:0] m_addr = '0;

    bit last_acc;
    bit last_rdy;
    bit last_iv;

    typedef struct {
        bit            pv;
        logic [AW-1:0] p;
        bit            g;
        bit            rv;
        logic [IW-1:0] rd;
        bit            ir;
        bit            e_rdy;
        bit            e_req;
        bit            e_iv;
        logic [IW-1:0] e_ins;
        logic [AW-1:0] e_pc;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit fault_pc(input logic [AW-1:0] p);
        return ALIGN_EN && (p[1:0] != 2'b00);
    endfunction

    function automatic bit m_pc_ready(input bit fl);
        return !m_wait_gnt && !m_wait_data && !m_drop && (q.size() < D) && !fl;
    endfunction

    task automatic drive(input bit pv, input logic [AW-1:0] p, input bit fl, input bit g,
                         input bit rv, input logic [IW-1:0] rd, input bit ir);
        bus.pc_valid    = pv;
        bus.pc          = p;
        bus.flush       = fl;
        bus.mem_gnt     = g;
        bus.mem_rvalid  = rv;
        bus.mem_rdata   = rd;
        bus.instr_ready = ir;
    endtask

    task automatic model_check();
        chk("pc_ready", bus.pc_ready, m_pc_ready(bus.flush));
        chk("mem_req", bus.mem_req, m_wait_gnt);
        if (m_wait_gnt) chk("mem_addr", bus.mem_addr, m_addr);
        chk("instr_valid", bus.instr_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instr", bus.instr, q[0].ins);
            chk("instr_pc", bus.instr_pc, q[0].pc);
`ifdef FETCH_ALIGN_CHECK_EN
            chk("instr_fault", bus.instr_fault, q[0].flt);
`endif
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit rdy;
        rdy = m_pc_ready(bus.flush);
        if (bus.flush) begin
            q.delete();
            if (m_wait_gnt) begin
                m_wait_gnt = 1'b0;
            end else if (m_wait_data) begin
                m_wait_data = 1'b0;
                m_drop      = !bus.mem_rvalid;
            end else if (m_drop && bus.mem_rvalid) begin
                m_drop = 1'b0;
            end
        end else begin
            if (bus.instr_ready && q.size() != 0) void'(q.pop_front());
            if (m_wait_gnt && bus.mem_gnt) begin
                m_wait_gnt  = 1'b0;
                m_wait_data = 1'b1;
            end else if (m_wait_data && bus.mem_rvalid) begin
                m_wait_data = 1'b0;
                q.push_back('{m_addr, bus.mem_rdata, 1'b0});
            end else if (m_drop && bus.mem_rvalid) begin
                m_drop = 1'b0;
            end
            if (bus.pc_valid && rdy) begin
                if (fault_pc(bus.pc)) begin
                    q.push_back('{bus.pc, 32'h0, 1'b1});
                end else begin
                    m_wait_gnt = 1'b1;
                    m_addr     = bus.pc;
                end
            end
        end
    endtask

    task automatic cycle(input bit pv, input logic [AW-1:0] p, input bit fl, input bit g,
                         input bit rv, input logic [IW-1:0] rd, input bit ir);
        drive(pv, p, fl, g, rv, rd, ir);
        #3;
        last_rdy = bus.pc_ready;
        last_acc = bus.pc_valid && bus.pc_ready;
        last_iv  = bus.instr_valid;
        model_check();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_one(input logic [AW-1:0] p, input bit ir);
        int tries;
        tries    = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 20) begin
            cycle(1'b1, p, 1'b0, 1'b0, 1'b0, 32'h0, ir);
            tries++;
        end
        if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
        if (!fault_pc(p)) begin
            cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0, ir);
            cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'hA000_0000 | p[31:0], ir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bit            mem_out;
        bit            fl, pv, g, rv, ir;
        logic [AW-1:0] p;
        logic [IW-1:0] rd;

        vt[0] = '{1'b1, 64'h1000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        64'h0};
        vt[1] = '{1'b0, 64'h0,    1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        64'h1000};
        vt[2] = '{1'b0, 64'h0,    1'b0, 1'b1, 32'h8B020020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        64'h0};
        vt[3] = '{1'b0, 64'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h8B020020, 64'h1000};
        vt[4] = '{1'b0, 64'h0,    1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h8B020020, 64'h1000};
        vt[5] = '{1'b0, 64'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        64'h0};

        // Reset held low with a pending PC
        reset = 1'b0;
        drive(1'b1, 64'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #3;
            chk($sformatf("rst%0d_pc_ready", i), bus.pc_ready, 64'd0);
            chk($sformatf("rst%0d_mem_req", i), bus.mem_req, 64'd0);
            chk($sformatf("rst%0d_instr_valid", i), bus.instr_valid, 64'd0);
        end
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_instr", bus.instr, 64'd0);
        chk("rst_instr_pc", bus.instr_pc, 64'd0);
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_release_pc_ready", bus.pc_ready, 64'd1);
        @(posedge clock);
        #1;

        // Single fetch with minimum latency
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].pv, vt[i].p, 1'b0, vt[i].g, vt[i].rv, vt[i].rd, vt[i].ir);
            #3;
            chk($sformatf("tbl%0d_pc_ready", i), bus.pc_ready, vt[i].e_rdy);
            chk($sformatf("tbl%0d_mem_req", i), bus.mem_req, vt[i].e_req);
            if (vt[i].e_req) chk($sformatf("tbl%0d_mem_addr", i), bus.mem_addr, vt[i].e_pc);
            chk($sformatf("tbl%0d_instr_valid", i), bus.instr_valid, vt[i].e_iv);
            if (vt[i].e_iv) begin
                chk($sformatf("tbl%0d_instr", i), bus.instr, vt[i].e_ins);
                chk($sformatf("tbl%0d_instr_pc", i), bus.instr_pc, vt[i].e_pc);
            end
            model_update();
            @(posedge clock);
            #1;
        end

        // Fill the FIFO, check backpressure, then drain in order
        for (int k = 0; k < 4; k++) fetch_one(64'(k * 4), 1'b0);
        cycle(1'b1, 64'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("full_pc_ready", last_rdy, 64'd0);
        chk("head_order0", bus.instr_pc, 64'h0);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        fetch_one(64'h10, 1'b0);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("head_order%0d", k), bus.instr_pc, 64'(k * 4));
            cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end

        // Flush while waiting for data; the late return is dropped
        cycle(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("discard_pc_ready_low", last_rdy, 64'd0);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("discard_pc_ready_back", last_rdy, 64'd1);
        chk("discard_no_push", last_iv, 64'd0);

        // Flush with three buffered entries while decode is popping
        fetch_one(64'h3000, 1'b0);
        fetch_one(64'h3004, 1'b0);
        fetch_one(64'h3008, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("flush_clears", last_iv, 64'd0);
        fetch_one(64'h300C, 1'b0);
        chk("post_flush_head", bus.instr_pc, 64'h300C);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("post_flush_empty", last_iv, 64'd0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC becomes a faulting entry with no memory request
        cycle(1'b1, 64'h1002, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("align_no_req", bus.mem_req, 64'd0);
        chk("align_valid", bus.instr_valid, 64'd1);
        chk("align_fault", bus.instr_fault, 64'd1);
        chk("align_instr", bus.instr, 64'd0);
        chk("align_pc", bus.instr_pc, 64'h1002);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
`endif

        // Randomized traffic against the model
        mem_out = 1'b0;
        for (int n = 0; n < 800; n++) begin
            fl = ($urandom_range(15) == 0);
            pv = 1'($urandom_range(1));
            p  = {$urandom(), $urandom()};
            if (ALIGN_EN && $urandom_range(3) != 0) p[1:0] = 2'b00;
            g  = bus.mem_req && !fl && ($urandom_range(1) == 1);
            rv = mem_out && ($urandom_range(2) == 0);
            rd = $urandom();
            ir = 1'($urandom_range(1));
            cycle(pv, p, fl, g, rv, rd, ir);
            if (rv) mem_out = 1'b0;
            else if (g) mem_out = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
